axi4_lite_slave_regfile: RTL and testbench

AXI4_LITE_SLAVE_REGFILE -- requirements
Module: axi4_lite_slave_regfile

---
 rtl/axi4_lite_slave_regfile.sv | 222 ++++++++++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave_regfile
// AXI4-Lite slave exposing NUM_REGS registers of DATA_WIDTH bits. Addresses
// are register indices (not byte addresses). Out-of-range accesses get
// SLVERR and never touch the register array.
//
// Ports
//   ACLK, ARESETN              clock (rising edge), async active-low reset
//   AWADDR/AWVALID/AWREADY     write address channel
//   WDATA/WSTRB/WVALID/WREADY  write data channel
//   BRESP/BVALID/BREADY        write response channel
//   ARADDR/ARVALID/ARREADY     read address channel
//   RDATA/RRESP/RVALID/RREADY  read data channel
//
// Write FSM
//   state       | meaning
//   W_IDLE      | AW and W both accepted
//   W_ADDR_HELD | address captured, waiting for W
//   W_DATA_HELD | data/strobe captured, waiting for AW
//   W_RESP      | register updated, BVALID high until BREADY
//
// Read FSM
//   state       | meaning
//   R_IDLE      | AR accepted
//   R_RESP      | RDATA/RRESP registered, RVALID high until RREADY
// ---------------------------------------------------------------------------
module axi4_lite_slave_regfile #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDRESS_WIDTH-1:0]  AWADDR,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic [DATA_WIDTH/8-1:0]   WSTRB,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  input  logic [ADDRESS_WIDTH-1:0]  ARADDR,
  input  logic                      ARVALID,
  output logic                      ARREADY,
  output logic [DATA_WIDTH-1:0]     RDATA,
  output logic [1:0]                RRESP,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_LIMIT = ADDRESS_WIDTH'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_HELD = 2'd1,
    W_DATA_HELD = 2'd2,
    W_RESP      = 2'd3
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [DATA_WIDTH-1:0]    regs [NUM_REGS];
  logic [ADDRESS_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [STRB_W-1:0]        wstrb_q;
  logic                     bvalid_q;
  logic [1:0]               bresp_q;
  logic                     rvalid_q;
  logic [1:0]               rresp_q;
  logic [DATA_WIDTH-1:0]    rdata_q;

  logic                     aw_hs;
  logic                     w_hs;
  logic                     wr_commit;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic [STRB_W-1:0]        wr_strb;
  logic                     wr_ok;
  logic [IDX_W-1:0]         wr_idx;
  logic                     rd_ok;
  logic [IDX_W-1:0]         rd_idx;

  // Ready flags decode straight from the state registers, so they are
  // glitch-free and all read as 1 while reset holds both FSMs in idle.
  assign AWREADY = (w_state == W_IDLE) || (w_state == W_DATA_HELD);
  assign WREADY  = (w_state == W_IDLE) || (w_state == W_ADDR_HELD);
  assign ARREADY = (r_state == R_IDLE);
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign RVALID  = rvalid_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  always_comb begin
    aw_hs     = AWVALID && AWREADY;
    w_hs      = WVALID && WREADY;
    wr_commit = ((w_state == W_IDLE)      && aw_hs && w_hs) ||
                ((w_state == W_ADDR_HELD) && w_hs)          ||
                ((w_state == W_DATA_HELD) && aw_hs);
    // The commit edge may be the same edge that delivers one of the two
    // beats, so take that beat from the bus rather than the holding register.
    wr_addr   = aw_hs ? AWADDR : awaddr_q;
    wr_data   = w_hs  ? WDATA  : wdata_q;
    wr_strb   = w_hs  ? WSTRB  : wstrb_q;
    wr_ok     = (wr_addr < ADDR_LIMIT);
    wr_idx    = wr_addr[IDX_W-1:0];
    rd_ok     = (ARADDR < ADDR_LIMIT);
    rd_idx    = ARADDR[IDX_W-1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      // Handshakes only happen in states that leave W_RESP untouched, so the
      // holding registers stay frozen for the whole response phase.
      if (aw_hs) begin
        awaddr_q <= AWADDR;
      end
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end

      if (wr_commit) begin
        if (wr_ok) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) begin
              regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
          end
        end
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        bvalid_q <= 1'b1;
      end

      case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            w_state <= W_RESP;
          end else if (aw_hs) begin
            w_state <= W_ADDR_HELD;
          end else if (w_hs) begin
            w_state <= W_DATA_HELD;
          end
        end
        W_ADDR_HELD: begin
          if (wr_commit) begin
            w_state <= W_RESP;
          end
        end
        W_DATA_HELD: begin
          if (wr_commit) begin
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Reads sample the array with non-blocking semantics, so a read accepted on
  // a write's commit edge returns the pre-write contents.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            r_state  <= R_RESP;
            rvalid_q <= 1'b1;
            if (rd_ok) begin
              rdata_q <= regs[rd_idx];
              rresp_q <= RESP_OKAY;
            end else begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
          end
        end
        R_RESP: begin
          if (RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slave_regfile
// Directed bench for axi4_lite_slave_regfile (default parameters). Inputs
// change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave_regfile;

  logic        ACLK    = 1'b0;
  logic        ARESETN = 1'b1;
  logic [31:0] AWADDR  = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA   = '0;
  logic [3:0]  WSTRB   = '0;
  logic        WVALID  = 1'b0;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY  = 1'b0;
  logic [31:0] ARADDR  = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY  = 1'b0;

  int checks = 0;
  int errors = 0;

  axi4_lite_slave_regfile #(
    .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .NUM_REGS(32)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // AW and W presented together; response accepted one cycle later.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] resp);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_bvalid", BVALID, 1'b1);
    chk("wr_bresp", BRESP, resp);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    chk("wr_bvalid_clr", BVALID, 1'b0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp);
    ARADDR = a; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    chk("rd_rvalid", RVALID, 1'b1);
    chk("rd_rdata", RDATA, d);
    chk("rd_rresp", RRESP, resp);
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    chk("rd_rvalid_clr", RVALID, 1'b0);
  endtask

  initial begin
    // Reset state
    #2 ARESETN = 1'b0;
    #10;
    chk("rst_awready", AWREADY, 1'b1);
    chk("rst_wready", WREADY, 1'b1);
    chk("rst_arready", ARREADY, 1'b1);
    chk("rst_bvalid", BVALID, 1'b0);
    chk("rst_rvalid", RVALID, 1'b0);
    chk("rst_bresp", BRESP, 2'b00);
    chk("rst_rresp", RRESP, 2'b00);
    chk("rst_rdata", RDATA, 32'h0);
    tick();
    ARESETN = 1'b1;
    tick();

    // AW and W in the same cycle
    do_write(32'd5, 32'hA5A5A5A5, 4'hF, 2'b00);
    do_read(32'd5, 32'hA5A5A5A5, 2'b00);

    // W two cycles ahead of AW; bus data changes after W handshake
    WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0; WDATA = 32'hCAFEF00D; WSTRB = 4'h0;
    chk("wfirst_wready", WREADY, 1'b0);
    chk("wfirst_awready", AWREADY, 1'b1);
    chk("wfirst_bvalid", BVALID, 1'b0);
    tick();
    chk("wfirst_bvalid2", BVALID, 1'b0);
    AWADDR = 32'd10; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    chk("wfirst_bvalid3", BVALID, 1'b1);
    chk("wfirst_bresp", BRESP, 2'b00);
    chk("wfirst_awready_resp", AWREADY, 1'b0);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    do_read(32'd10, 32'h12345678, 2'b00);
    do_read(32'd15, 32'h0, 2'b00);

    // Out-of-range write/read; 40 must not alias onto 8
    do_write(32'd40, 32'hDEADBEEF, 4'hF, 2'b10);
    do_read(32'd40, 32'h0, 2'b10);
    do_read(32'd8, 32'h0, 2'b00);
    do_write(32'h0000_0105, 32'h0BAD0BAD, 4'hF, 2'b10);
    do_read(32'd5, 32'hA5A5A5A5, 2'b00);

    // Byte strobes
    do_write(32'd2, 32'hFFFFFFFF, 4'hF, 2'b00);
    do_write(32'd2, 32'h00000000, 4'b0011, 2'b00);
    do_read(32'd2, 32'hFFFF0000, 2'b00);

    // AW ahead of W; bus address changes after AW handshake
    AWADDR = 32'd7; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0; AWADDR = 32'd9;
    chk("afirst_awready", AWREADY, 1'b0);
    chk("afirst_wready", WREADY, 1'b1);
    WDATA = 32'h0F0F1234; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    chk("afirst_bvalid", BVALID, 1'b1);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    do_read(32'd7, 32'h0F0F1234, 2'b00);
    do_read(32'd9, 32'h0, 2'b00);

    // Read accepted on the write's commit edge sees the old value
    AWADDR = 32'd5; WDATA = 32'h11111111; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; ARADDR = 32'd5; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    chk("rw_rdata_old", RDATA, 32'hA5A5A5A5);
    chk("rw_bvalid", BVALID, 1'b1);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    do_read(32'd5, 32'h11111111, 2'b00);

    // Stalled responses, then reset mid-response
    do_write(32'd3, 32'h87654321, 4'hF, 2'b00);
    AWADDR = 32'd50; WDATA = 32'h55555555; WSTRB = 4'hF;
    AWVALID = 1'b1; WVALID = 1'b1; ARADDR = 32'd3; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    // AW/W stay asserted: any further acceptance would be a bug
    AWADDR = 32'd4; WDATA = 32'h99999999;
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", BVALID, 1'b1);
      chk("stall_bresp", BRESP, 2'b10);
      chk("stall_rvalid", RVALID, 1'b1);
      chk("stall_rdata", RDATA, 32'h87654321);
      chk("stall_rresp", RRESP, 2'b00);
      chk("stall_awready", AWREADY, 1'b0);
      chk("stall_wready", WREADY, 1'b0);
      chk("stall_arready", ARREADY, 1'b0);
      tick();
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    #2 ARESETN = 1'b0;
    #1;
    chk("midrst_bvalid", BVALID, 1'b0);
    chk("midrst_rvalid", RVALID, 1'b0);
    chk("midrst_rdata", RDATA, 32'h0);
    chk("midrst_awready", AWREADY, 1'b1);
    tick();
    ARESETN = 1'b1;
    tick();
    do_read(32'd3, 32'h0, 2'b00);
    do_read(32'd4, 32'h0, 2'b00);

    // Reset after AW-only handshake: transaction abandoned
    AWADDR = 32'd6; AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    WDATA = 32'h77777777; WSTRB = 4'hF;
    #2 ARESETN = 1'b0;
    #3;
    tick();
    ARESETN = 1'b1;
    tick();
    chk("abandon_wready", WREADY, 1'b1);
    chk("abandon_awready", AWREADY, 1'b1);
    tick();
    tick();
    chk("abandon_bvalid", BVALID, 1'b0);
    do_read(32'd6, 32'h0, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
